// File: rtl/bundle_beat_serializer_pkg.sv
// Shared widths, chunk offsets and FSM encoding for the bundle beat serializer.
package bundle_beat_serializer_pkg;

    localparam int unsigned WORD_W = 126;
    localparam int unsigned BEAT_W = 52;
    localparam int unsigned C1_W   = 42;
    localparam int unsigned C2_W   = 32;
    localparam int unsigned IDX_W  = 2;

    localparam int unsigned C0_LSB = 0;
    localparam int unsigned C1_LSB = 52;
    localparam int unsigned C2_LSB = 94;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/bundle_chunk_mux.sv
// Selects one chunk of the held word and zero-extends it to a full beat.
module bundle_chunk_mux
    import bundle_beat_serializer_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    output logic [BEAT_W-1:0] chunk
);

    always_comb begin
        chunk = '0;
        case (idx)
            2'd0:    chunk                = word[C0_LSB +: BEAT_W];
            2'd1:    chunk[C1_W-1:0]      = word[C1_LSB +: C1_W];
            2'd2:    chunk[C2_W-1:0]      = word[C2_LSB +: C2_W];
            default: chunk                = '0;
        endcase
    end

endmodule

// File: rtl/bundle_beat_serializer.sv
// Serializes a 126-bit group-vector word into three beats with a completed-word counter.
module bundle_beat_serializer
    import bundle_beat_serializer_pkg::*;
#(
    parameter int unsigned REVERSE = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  words_done
);

    localparam logic [IDX_W-1:0] FIRST_IDX = (REVERSE != 0) ? 2'd2 : 2'd0;
    localparam logic [IDX_W-1:0] LAST_IDX  = (REVERSE != 0) ? 2'd0 : 2'd2;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   hold_q, hold_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BEAT_W-1:0]   chunk;

    bundle_chunk_mux u_chunk_mux (
        .word  (hold_q),
        .idx   (idx_q),
        .chunk (chunk)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = !abort;
                if (in_valid && !abort) begin
                    hold_d  = in_data;
                    idx_d   = FIRST_IDX;
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = chunk;
                out_idx   = idx_q;
                out_last  = (idx_q == LAST_IDX);
                if (out_ready && !abort) begin
                    if (out_last) begin
                        // Final beat frees the holder this cycle, so a waiting word loads with no bubble.
                        in_ready = 1'b1;
                        cnt_d    = cnt_q + CNT_W'(1);
                        if (in_valid) begin
                            hold_d = in_data;
                            idx_d  = FIRST_IDX;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (REVERSE != 0) begin
                        idx_d = idx_q - 2'd1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            hold_d  = '0;
        end
    end

    assign words_done = cnt_q;

endmodule

// File: doc/bundle_beat_serializer.md
BUNDLE_BEAT_SERIALIZER -- requirements
Module: bundle_beat_serializer

Interface
REQ-001 The block SHALL have parameter REVERSE, default 0, meaning beat order: 0 sends chunk 0 first, 1 sends chunk 2 first.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the completed-word counter.
REQ-003 Port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  producer presents a packed 126-bit group-vector word.
REQ-006 Port in_ready  output  1  block accepts in_data this cycle.
REQ-007 Port in_data  input  126  packed word: chunk 0 = [51:0], chunk 1 = [93:52], chunk 2 = [125:94].
REQ-008 Port abort  input  1  synchronous flush of the word in flight.
REQ-009 Port out_valid  output  1  out_data holds a valid beat.
REQ-010 Port out_ready  input  1  consumer accepts the beat.
REQ-011 Port out_data  output  52  current chunk, zero-extended to 52 bits.
REQ-012 Port out_idx  output  2  chunk number (0..2) of the current beat.
REQ-013 Port out_last  output  1  high on the final beat of a word.
REQ-014 Port busy  output  1  high while a word is held.
REQ-015 Port words_done  output  CNT_W  count of fully transmitted words.

Function
REQ-016 FSM states SHALL be IDLE and SEND.
REQ-017 A handshake SHALL occur on a side only when valid and ready are both high in the same cycle.
REQ-018 In IDLE: in_ready=1 and out_valid=0; an in handshake captures in_data into a 126-bit holding register, sets the beat index to the first index, and moves the FSM to SEND.
REQ-019 The first beat SHALL appear on out_data exactly one cycle after the in handshake.
REQ-020 In SEND: out_valid=1; out_data, out_idx and out_last SHALL be stable until the out handshake.
REQ-021 Beat order SHALL be 0,1,2 when REVERSE=0 and 2,1,0 when REVERSE=1; out_last is high only on the third beat.
REQ-022 A non-final out handshake SHALL advance the index by one step; the index never takes the value 3.
REQ-023 in_ready SHALL be high in SEND only during the final-beat out handshake; this is a combinational path from out_ready.
REQ-024 On a final-beat handshake with in_valid=1, the block SHALL load the new word and stay in SEND with no bubble; with in_valid=0 it returns to IDLE.
REQ-025 words_done SHALL increment by 1 on each final-beat handshake and wrap from all-ones to 0.
REQ-026 abort=1 SHALL force IDLE on the next edge, discard the held word, leave words_done unchanged, and hold in_ready low in that cycle.
REQ-027 abort together with a final-beat handshake: abort wins and no count or load occurs.
REQ-028 busy SHALL equal (state==SEND).

Reset
REQ-029 While reset_n=0, the block SHALL hold: state IDLE, out_valid=0, in_ready=1, busy=0, out_data=0, out_idx=0, out_last=0, words_done=0, holding register 0.
REQ-030 Reset asserted mid-word SHALL drop the word immediately, with no further beats after release.

Structure
REQ-031 A shared package SHALL hold the widths (126, 52, 42, 32), the chunk bit offsets and the FSM state enum.
REQ-032 A sub-module bundle_chunk_mux SHALL select and zero-extend the chunk for a given index; the FSM, counter and registers live in the top module.

Verification
REQ-033 in_data chunks [51:0]=52'hABCDEF0123456, [93:52]=42'h15555555555, [125:94]=32'hDEADBEEF, out_ready=1, REVERSE=0 -> beats 52'hABCDEF0123456 (idx0), 52'h0015555555555 (idx1), 52'h00000DEADBEEF (idx2, last); words_done=1.
REQ-034 Same word with REVERSE=1 -> idx order 2,1,0; out_last on idx0.
REQ-035 Two words back-to-back, in_valid held high, out_ready=1 -> 6 consecutive beats with no idle cycle; in_ready pulses only on the final beat; words_done=2.
REQ-036 out_ready toggling 1,0,0,1 during a word -> each beat is held stable while out_ready=0; no beat is lost or duplicated.
REQ-037 abort during beat idx1, then reset_n low during a later word's idx0 -> IDLE after each event; words_done unchanged by abort and 0 after reset.
REQ-038 CNT_W=2, five words sent -> words_done reads 1, 2, 3, 0, 1.
